// File: rtl/common_pkg.sv
// Shared bus-level types: machine word, data-bus request/response and access sizes.
package common;

    typedef logic [63:0] word_t;
    typedef logic [63:0] addr_t;
    typedef logic [2:0]  msize_t;
    typedef logic [7:0]  strobe_t;

    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;
    localparam msize_t MSIZE8 = 3'd3;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline stage payloads between execute and memory, plus the memory-stage FSM state.
package pipes;
    import common::*;

    typedef logic [4:0] creg_addr_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        creg_addr_t dst;
        logic       b_jump;
    } control_t;

    typedef struct packed {
        word_t    result;
        word_t    memdata;
        control_t ctl;
    } execute_data_t;

    typedef struct packed {
        word_t      result;
        logic       regwrite;
        creg_addr_t dst;
    } memory_data_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_access_mem_req_gen.sv
// Forms the data-bus request from the latched access; the request is idle unless busy.
module mem_req_gen
    import common::*;
(
    input  logic      busy,
    input  logic      is_load,
    input  addr_t     addr,
    input  word_t     data,
    output dbus_req_t dreq
);

    always_comb begin
        dreq = '0;
        if (busy) begin
            dreq.valid  = 1'b1;
            dreq.addr   = addr;
            dreq.size   = MSIZE8;
            dreq.strobe = is_load ? 8'h00 : 8'hFF;
            dreq.data   = is_load ? '0 : data;
        end
    end

endmodule

// File: rtl/memory_access.sv
// Memory stage: ALU results pass through in one cycle; loads/stores hold the pipe
// until the data bus reports data_ok, then retire with a single valid_out pulse.
module memory_access
    import common::*;
    import pipes::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          valid_in,
    output logic          stall,
    output memory_data_t  dataM,
    output logic          valid_out,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp
);

    mem_state_t   state_q, state_d;
    addr_t        addr_q, addr_d;
    word_t        memdata_q, memdata_d;
    logic         regwrite_q, regwrite_d;
    creg_addr_t   dst_q, dst_d;
    logic         is_load_q, is_load_d;
    memory_data_t data_m_q, data_m_d;
    logic         valid_out_q, valid_out_d;
    logic         mem_op;

    // Fields this stage deliberately does not consume.
    logic unused_bits;
    assign unused_bits = ^{dataE.ctl.b_jump, dresp.addr_ok};

    assign mem_op = dataE.ctl.memread | dataE.ctl.memwrite;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        memdata_d   = memdata_q;
        regwrite_d  = regwrite_q;
        dst_d       = dst_q;
        is_load_d   = is_load_q;
        data_m_d    = data_m_q;
        valid_out_d = 1'b0;
        stall       = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (mem_op) begin
                        stall      = 1'b1;
                        state_d    = BUSY;
                        addr_d     = dataE.result;
                        memdata_d  = dataE.memdata;
                        regwrite_d = dataE.ctl.regwrite;
                        dst_d      = dataE.ctl.dst;
                        // Both flags set resolves to a load.
                        is_load_d  = dataE.ctl.memread;
                    end else begin
                        data_m_d    = '{result: dataE.result, regwrite: dataE.ctl.regwrite,
                                        dst: dataE.ctl.dst};
                        valid_out_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = ~dresp.data_ok;
                if (dresp.data_ok) begin
                    state_d     = IDLE;
                    data_m_d    = '{result: is_load_q ? dresp.data : addr_q,
                                    regwrite: regwrite_q, dst: dst_q};
                    valid_out_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            memdata_q   <= '0;
            regwrite_q  <= 1'b0;
            dst_q       <= '0;
            is_load_q   <= 1'b0;
            data_m_q    <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            memdata_q   <= memdata_d;
            regwrite_q  <= regwrite_d;
            dst_q       <= dst_d;
            is_load_q   <= is_load_d;
            data_m_q    <= data_m_d;
            valid_out_q <= valid_out_d;
        end
    end

    mem_req_gen u_mem_req_gen (
        .busy    ((state_q == BUSY) && !reset),
        .is_load (is_load_q),
        .addr    (addr_q),
        .data    (memdata_q),
        .dreq    (dreq)
    );

    assign dataM     = data_m_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_memory_access.sv
// Randomized self-checking bench for memory_access against a transaction-level model.
module tb_memory_access;
    import common::*;
    import pipes::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    logic          valid_in;
    logic          stall;
    memory_data_t  dataM;
    logic          valid_out;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: the retirement expected at the next edge, and the last retired payload.
    memory_data_t exp_dm;
    memory_data_t last_dm;
    logic         exp_pulse;

    always #5 clk = ~clk;

    memory_access dut (
        .clk       (clk),
        .reset     (reset),
        .dataE     (dataE),
        .valid_in  (valid_in),
        .stall     (stall),
        .dataM     (dataM),
        .valid_out (valid_out),
        .dreq      (dreq),
        .dresp     (dresp)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rand_resp(input logic ok);
        dresp.addr_ok = 1'($urandom);
        dresp.data_ok = ok;
        dresp.data    = {$urandom, $urandom};
    endtask

    // Advance one edge, then check the registered outputs against the model.
    task automatic step();
        @(posedge clk);
        #1;
        check_eq("valid_out", valid_out, exp_pulse);
        if (exp_pulse) last_dm = exp_dm;
        check_eq("dataM.result", dataM.result, last_dm.result);
        check_eq("dataM.regwrite", dataM.regwrite, last_dm.regwrite);
        check_eq("dataM.dst", dataM.dst, last_dm.dst);
        exp_pulse = 1'b0;
    endtask

    task automatic do_idle();
        valid_in       = 1'b0;
        dataE          = '{result: {$urandom, $urandom}, memdata: {$urandom, $urandom},
                           ctl: control_t'($urandom)};
        rand_resp(1'($urandom));
        #1;
        check_eq("idle.stall", stall, 1'b0);
        check_eq("idle.dreq.valid", dreq.valid, 1'b0);
        step();
    endtask

    task automatic do_alu(input word_t res, input logic rw, input logic [4:0] dst);
        valid_in       = 1'b1;
        dataE.result   = res;
        dataE.memdata  = {$urandom, $urandom};
        dataE.ctl      = '{memread: 1'b0, memwrite: 1'b0, regwrite: rw, dst: dst,
                           b_jump: 1'($urandom)};
        rand_resp(1'($urandom));
        #1;
        check_eq("alu.stall", stall, 1'b0);
        check_eq("alu.dreq.valid", dreq.valid, 1'b0);
        $display("[TB] alu   result=%h rw=%0d dst=%0d", res, rw, dst);
        exp_dm    = '{result: res, regwrite: rw, dst: dst};
        exp_pulse = 1'b1;
        step();
    endtask

    task automatic do_mem(input logic rd, input logic wr, input word_t addr, input word_t mdata,
                          input logic rw, input logic [4:0] dst, input int waits,
                          input word_t rdata);
        logic is_load;
        is_load       = rd;
        valid_in      = 1'b1;
        dataE.result  = addr;
        dataE.memdata = mdata;
        dataE.ctl     = '{memread: rd, memwrite: wr, regwrite: rw, dst: dst,
                          b_jump: 1'($urandom)};
        rand_resp(1'($urandom));
        #1;
        check_eq("mem.accept.stall", stall, 1'b1);
        check_eq("mem.accept.dreq.valid", dreq.valid, 1'b0);
        $display("[TB] %s addr=%h data=%h rw=%0d dst=%0d waits=%0d",
                 is_load ? "load " : "store", addr, is_load ? rdata : mdata, rw, dst, waits);
        step();
        for (int k = 0; k <= waits; k++) begin
            logic ok;
            ok = (k == waits);
            rand_resp(ok);
            if (ok) dresp.data = rdata;
            #1;
            check_eq("busy.dreq.valid", dreq.valid, 1'b1);
            check_eq("busy.dreq.addr", dreq.addr, addr);
            check_eq("busy.dreq.size", dreq.size, MSIZE8);
            check_eq("busy.dreq.strobe", dreq.strobe, is_load ? 8'h00 : 8'hFF);
            if (!is_load) check_eq("busy.dreq.data", dreq.data, mdata);
            check_eq("busy.stall", stall, !ok);
            if (ok) begin
                exp_dm    = '{result: is_load ? rdata : addr, regwrite: rw, dst: dst};
                exp_pulse = 1'b1;
            end
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        dataE     = '0;
        dresp     = '0;
        last_dm   = '0;
        exp_dm    = '0;
        exp_pulse = 1'b0;
        @(posedge clk);
        #1;
        step();
        check_eq("reset.stall", stall, 1'b0);
        check_eq("reset.dreq.valid", dreq.valid, 1'b0);
        reset = 1'b0;

        // Directed scenarios.
        do_alu(64'h10, 1'b1, 5'd5);
        do_mem(1'b1, 1'b0, 64'h8000_0000, 64'h55, 1'b1, 5'd7, 2, 64'hDEAD_BEEF);
        do_alu(64'h77, 1'b1, 5'd3);
        do_idle();
        do_mem(1'b0, 1'b1, 64'h8000_0008, 64'h1234, 1'b0, 5'd0, 0, 64'h0);
        do_mem(1'b1, 1'b1, 64'h8000_0010, 64'h9999, 1'b1, 5'd9, 1, 64'hCAFE_F00D_1234_5678);
        do_idle();

        // Reset in the second busy cycle abandons the access; a late data_ok is ignored.
        valid_in      = 1'b1;
        dataE.result  = 64'h8000_0020;
        dataE.memdata = 64'h0;
        dataE.ctl     = '{memread: 1'b1, memwrite: 1'b0, regwrite: 1'b1, dst: 5'd4, b_jump: 1'b0};
        rand_resp(1'b0);
        $display("[TB] load  addr=%h aborted by reset", dataE.result);
        step();
        rand_resp(1'b0);
        #1;
        check_eq("abort.busy1.dreq.valid", dreq.valid, 1'b1);
        step();
        reset = 1'b1;
        rand_resp(1'b0);
        #1;
        check_eq("abort.rst.stall", stall, 1'b0);
        check_eq("abort.rst.dreq.valid", dreq.valid, 1'b0);
        last_dm = '0;
        step();
        reset    = 1'b0;
        valid_in = 1'b0;
        rand_resp(1'b1);
        #1;
        check_eq("abort.late_ok.stall", stall, 1'b0);
        check_eq("abort.late_ok.dreq.valid", dreq.valid, 1'b0);
        step();
        do_idle();

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            int    kind;
            word_t a;
            kind = int'($urandom_range(0, 4));
            a    = {$urandom, $urandom};
            case (kind)
                0: do_idle();
                1: do_alu(a, 1'($urandom), 5'($urandom));
                2: do_mem(1'b1, 1'b0, a, {$urandom, $urandom}, 1'($urandom), 5'($urandom),
                          int'($urandom_range(0, 3)), {$urandom, $urandom});
                3: do_mem(1'b0, 1'b1, a, {$urandom, $urandom}, 1'($urandom), 5'($urandom),
                          int'($urandom_range(0, 3)), {$urandom, $urandom});
                default: do_mem(1'b1, 1'b1, a, {$urandom, $urandom}, 1'($urandom),
                                5'($urandom), int'($urandom_range(0, 3)), {$urandom, $urandom});
            endcase
        end
        do_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit, a synchronous active-high reset.
REQ-003 The module SHALL have the port dataE, input, execute_data_t, carrying result (address or ALU value), memdata (store data) and ctl.{memread, memwrite, regwrite, dst, b_jump}.
REQ-004 The module SHALL have the port valid_in, input, 1 bit, meaning dataE holds a live instruction.
REQ-005 The module SHALL have the port stall, output, 1 bit; while it is 1, upstream holds dataE and valid_in stable.
REQ-006 The module SHALL have the port dataM, output, memory_data_t {result, regwrite, dst}, registered.
REQ-007 The module SHALL have the port valid_out, output, 1 bit, meaning dataM is live this cycle.
REQ-008 The module SHALL have the port dreq, output, dbus_req_t {valid, addr, size, strobe, data}.
REQ-009 The module SHALL have the port dresp, input, dbus_resp_t {addr_ok, data_ok, data}.

Function
REQ-010 The module SHALL implement an FSM with two states: IDLE and BUSY.
REQ-011 In IDLE, with valid_in=1 and no memory op (memread=memwrite=0), the module SHALL register dataM = {dataE.result, ctl.regwrite, ctl.dst} and set valid_out=1 on the next cycle, with stall=0 (latency 1).
REQ-012 In IDLE, with valid_in=1 and memread|memwrite, the module SHALL enter BUSY next cycle, latch addr, memdata, regwrite, dst and op, and drive stall=1 combinationally in the same cycle.
REQ-013 In BUSY, dreq.valid SHALL be 1 and constant in every cycle up to and including the data_ok cycle; addr_ok is ignored.
REQ-014 In BUSY, dreq.addr SHALL equal the latched result and dreq.size SHALL be MSIZE8.
REQ-015 For a load in BUSY, dreq.strobe SHALL be 0; for a store, dreq.strobe SHALL be 8'hFF and dreq.data SHALL equal the latched memdata.
REQ-016 If memread=memwrite=1, the instruction SHALL be treated as a load.
REQ-017 In the BUSY cycle with data_ok=1, stall SHALL be 0 and the state SHALL return to IDLE next cycle.
REQ-018 On completion of a load, the next cycle SHALL drive dataM.result = dresp.data (captured in the data_ok cycle) and valid_out=1.
REQ-019 On completion of a store, the next cycle SHALL drive dataM.result = latched address and valid_out=1, with regwrite as latched.
REQ-020 valid_out SHALL be 1 for exactly one cycle per accepted instruction; in any other cycle valid_out=0 and dataM holds its last value.
REQ-021 A new instruction presented in the cycle after completion SHALL be accepted with no bubble.
REQ-022 data_ok asserted while in IDLE SHALL be ignored.
REQ-023 valid_in=0 in IDLE SHALL leave the state in IDLE with stall=0.
REQ-024 ctl.b_jump SHALL not affect this block.

Reset
REQ-025 When reset=1 at a clock edge, the state SHALL become IDLE and valid_out, dataM (all fields), and the latched request SHALL be 0.
REQ-026 While reset=1, stall=0 and dreq.valid=0.
REQ-027 Reset in BUSY SHALL abandon the access; any later data_ok SHALL be ignored per REQ-022.

Structure
REQ-028 memory_data_t and the FSM state enum SHALL be defined in package pipes.
REQ-029 dbus_req_t, dbus_resp_t, word_t and the MSIZE* constants SHALL be defined in package common.
REQ-030 The RTL SHALL include one sub-module, mem_req_gen (combinational dreq formation from the latched op).

Verification
REQ-031 Reset then valid_in with add, result=0x10, dst=5 -> next cycle valid_out=1, dataM={0x10, 1, 5}, stall never 1.
REQ-032 Load addr=0x80000000, data_ok after 3 BUSY cycles with data 0xDEADBEEF -> dreq.valid high for 3 cycles, stall low in the data_ok cycle, dataM.result=0xDEADBEEF one cycle later.
REQ-033 Store addr=0x80000008, memdata=0x1234 with data_ok on the first BUSY cycle -> strobe=0xFF, data=0x1234, valid_out pulse with regwrite=0.
REQ-034 Load completion immediately followed by an ALU instruction -> two consecutive valid_out pulses with no gap.
REQ-035 Reset asserted in the second BUSY cycle, then data_ok the cycle after -> IDLE, dreq.valid=0, no valid_out pulse.
REQ-036 memread=memwrite=1 -> strobe=0 and load data returned.
